// File: rtl/unary2binary.sv
// rtl/unary2binary.sv - temporal unary-to-binary decoder with one-entry valid/ready output
// Optional feature macro: UNARY_GLITCH_FILTER_EN (edge needs two consecutive high samples)
module unary2binary #(
   parameter int GAMMA_CYCLE_WIDTH = 16,
   parameter int OUTPUT_WIDTH      = $clog2(GAMMA_CYCLE_WIDTH)
) (
   input  logic                    aclk,
   input  logic                    grst,
   input  logic                    unary_input,
   output logic                    gamma_start,
   output logic [OUTPUT_WIDTH-1:0] binary_output,
   output logic                    no_spike,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    overflow
);

   typedef enum logic {S_IDLE, S_CAPTURED} state_t;

   localparam logic [OUTPUT_WIDTH-1:0] LAST_PHASE = OUTPUT_WIDTH'(GAMMA_CYCLE_WIDTH - 1);
   localparam logic [OUTPUT_WIDTH-1:0] ONE        = OUTPUT_WIDTH'(1);

   state_t                  state_q;
   logic [OUTPUT_WIDTH-1:0] phase_q;
   logic [OUTPUT_WIDTH-1:0] cap_val_q;
   logic                    prev_q;
   logic                    valid_q;
   logic [OUTPUT_WIDTH-1:0] bin_q;
   logic                    ns_q;
   logic                    ovf_q;

   logic                    last_phase;
   logic                    edge_d;
   logic [OUTPUT_WIDTH-1:0] edge_val_d;
   logic [OUTPUT_WIDTH-1:0] res_val_d;
   logic                    res_ns_d;

   assign last_phase = (phase_q == LAST_PHASE);

   // The previous sample never reaches across a gamma boundary: at phase 0 it reads as 0.
   always_comb begin
      edge_d     = 1'b0;
      edge_val_d = phase_q;
`ifdef UNARY_GLITCH_FILTER_EN
      if (phase_q != '0 && prev_q && unary_input) begin
         edge_d     = 1'b1;
         edge_val_d = phase_q - ONE;
      end
`else
      if (unary_input && !((phase_q == '0) ? 1'b0 : prev_q)) begin
         edge_d = 1'b1;
      end
`endif
   end

   always_comb begin
      res_val_d = '0;
      res_ns_d  = 1'b1;
      if (state_q == S_CAPTURED) begin
         res_val_d = cap_val_q;
         res_ns_d  = 1'b0;
      end else if (edge_d) begin
         res_val_d = edge_val_d;
         res_ns_d  = 1'b0;
      end
   end

   always_ff @(posedge aclk) begin
      if (grst) begin
         state_q   <= S_IDLE;
         phase_q   <= '0;
         cap_val_q <= '0;
         prev_q    <= 1'b0;
         valid_q   <= 1'b0;
         bin_q     <= '0;
         ns_q      <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         prev_q <= unary_input;
         if (last_phase) begin
            phase_q   <= '0;
            state_q   <= S_IDLE;
            cap_val_q <= '0;
            // A full holding register that is not being drained loses the new result.
            if (!valid_q || out_ready) begin
               valid_q <= 1'b1;
               bin_q   <= res_val_d;
               ns_q    <= res_ns_d;
            end else begin
               ovf_q <= 1'b1;
            end
         end else begin
            phase_q <= phase_q + ONE;
            if (state_q == S_IDLE && edge_d) begin
               state_q   <= S_CAPTURED;
               cap_val_q <= edge_val_d;
            end
            if (valid_q && out_ready) begin
               valid_q <= 1'b0;
            end
         end
      end
   end

   assign gamma_start   = (phase_q == '0);
   assign binary_output = bin_q;
   assign no_spike      = ns_q;
   assign out_valid     = valid_q;
   assign overflow      = ovf_q;

endmodule
